// File: rtl/perm_collect.sv
// perm_collect: reassembles eight 200-bit permutation beats
// into a 1600-bit state and presents a digest with handshake.
module perm_collect #(
  parameter int DIGEST_W = 256,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pushin,
  input  logic [2:0]          dix,
  input  logic [199:0]        din,
  input  logic                digest_ready,
  output logic [DIGEST_W-1:0] digest,
  output logic                digest_valid,
  output logic                seq_err,
  output logic                overrun,
  output logic [CNT_W-1:0]    blk_cnt,
  output logic [CNT_W-1:0]    drop_cnt
);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [2:0]      exp_ix_q;
  logic [2:0]      exp_ix_d;
  logic [2:0]      exp_cur;
  logic [1599:0]   buf_q;
  logic [1599:0]   assembled;
  logic            hit;
  logic            miss;
  logic            store;
  logic            complete;
  logic            handshake;
  logic            load;
  logic            drop;

  assign exp_cur   = (state_q == IDLE) ? 3'd0 : exp_ix_q;
  assign hit       = pushin && (dix == exp_cur);
  assign miss      = pushin && (dix != exp_cur);
  assign store     = hit || (miss && (dix == 3'd0));
  assign complete  = hit && (dix == 3'd7);
  assign handshake = digest_valid && digest_ready;
  assign load      = complete &&
                     (!digest_valid || digest_ready);
  assign drop      = complete && digest_valid &&
                     !digest_ready;

  // beat 7 bypasses the buffer so the digest loads
  // on the same edge that accepts the last beat
  assign assembled = {din, buf_q[1399:0]};

  // next expected index and block state
  always_comb begin
    state_d  = state_q;
    exp_ix_d = exp_ix_q;
    unique case (1'b1)
      hit: begin
        exp_ix_d = dix + 3'd1;
        state_d  = complete ? IDLE : COLLECT;
      end
      miss: begin
        if (dix == 3'd0) begin
          exp_ix_d = 3'd1;
          state_d  = COLLECT;
        end else begin
          exp_ix_d = 3'd0;
          state_d  = IDLE;
        end
      end
      default: ;
    endcase
  end

  // block state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      exp_ix_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      exp_ix_q <= exp_ix_d;
    end
  end

  // assembly buffer: write accepted beat into its slice
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q <= '0;
    end else if (store) begin
      buf_q[int'(dix)*200 +: 200] <= din;
    end
  end

  // digest hold register and valid flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digest       <= '0;
      digest_valid <= 1'b0;
    end else if (load) begin
      digest       <= assembled[DIGEST_W-1:0];
      digest_valid <= 1'b1;
    end else if (handshake) begin
      digest_valid <= 1'b0;
    end
  end

  // one-cycle error pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      seq_err <= miss;
      overrun <= drop;
    end
  end

  // saturating delivered / dropped counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (handshake && (blk_cnt != '1))
        blk_cnt <= blk_cnt + 1'b1;
      if (drop && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

  logic unused_b7;
  assign unused_b7 = ^buf_q[1599:1400];

  if (DIGEST_W < 1600) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^assembled[1599:DIGEST_W];
  end

endmodule

// File: tb/tb_perm_collect.sv
// tb_perm_collect: directed checks of beat reassembly,
// sequencing errors, overrun and reset behaviour.
module tb_perm_collect;

  logic         clk;
  logic         reset;
  logic         pushin;
  logic [2:0]   dix;
  logic [199:0] din;
  logic         digest_ready;
  logic [255:0] digest;
  logic         digest_valid;
  logic         seq_err;
  logic         overrun;
  logic [15:0]  blk_cnt;
  logic [15:0]  drop_cnt;

  int checks;
  int errors;

  perm_collect #(
    .DIGEST_W(256),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pushin(pushin),
    .dix(dix),
    .din(din),
    .digest_ready(digest_ready),
    .digest(digest),
    .digest_valid(digest_valid),
    .seq_err(seq_err),
    .overrun(overrun),
    .blk_cnt(blk_cnt),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [199:0] pat(input int base,
                                       input int k);
    logic [7:0] b;
    b = 8'(base + k);
    return {25{b}};
  endfunction

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int k, input int base);
    pushin = 1'b1;
    dix    = 3'(k);
    din    = pat(base, k);
    step();
    pushin = 1'b0;
  endtask

  task automatic idle();
    pushin = 1'b0;
    step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_digest"}, digest, '0);
    chk({tag, "_valid"}, 256'(digest_valid), 0);
    chk({tag, "_seq"}, 256'(seq_err), 0);
    chk({tag, "_ovr"}, 256'(overrun), 0);
    chk({tag, "_blk"}, 256'(blk_cnt), 0);
    chk({tag, "_drop"}, 256'(drop_cnt), 0);
  endtask

  logic [255:0] exp_a;
  logic [255:0] exp_b;

  initial begin
    logic [199:0] t;
    checks = 0;
    errors = 0;
    t = pat(16, 1);
    exp_a = {t[55:0], pat(16, 0)};
    t = pat(32, 1);
    exp_b = {t[55:0], pat(32, 0)};

    reset = 1'b0;
    pushin = 1'b0;
    dix = 3'd0;
    din = '0;
    digest_ready = 1'b1;
    step();
    step();
    chk_zero("rst");
    reset = 1'b1;
    #2;
    chk_zero("rel");

    for (int k = 0; k < 7; k++) begin
      beat(k, 16);
      chk("b35_nv", 256'(digest_valid), 0);
    end
    beat(7, 16);
    chk("b35_valid", 256'(digest_valid), 1);
    chk("b35_digest", digest, exp_a);
    chk("b35_blk0", 256'(blk_cnt), 0);
    chk("b35_seq", 256'(seq_err), 0);
    idle();
    chk("b35_vclr", 256'(digest_valid), 0);
    chk("b35_blk1", 256'(blk_cnt), 1);

    for (int k = 0; k < 3; k++) beat(k, 16);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("b36_gap_seq", 256'(seq_err), 0);
    end
    for (int k = 3; k < 8; k++) begin
      beat(k, 16);
      chk("b36_seq", 256'(seq_err), 0);
    end
    chk("b36_valid", 256'(digest_valid), 1);
    chk("b36_digest", digest, exp_a);
    idle();
    chk("b36_blk", 256'(blk_cnt), 2);

    for (int k = 0; k < 3; k++) beat(k, 16);
    beat(5, 16);
    chk("b37_seq", 256'(seq_err), 1);
    idle();
    chk("b37_seq_clr", 256'(seq_err), 0);
    chk("b37_nv", 256'(digest_valid), 0);
    for (int k = 0; k < 8; k++) beat(k, 32);
    chk("b37_digest", digest, exp_b);
    chk("b37_valid", 256'(digest_valid), 1);
    idle();
    chk("b37_blk", 256'(blk_cnt), 3);

    for (int k = 0; k < 3; k++) beat(k, 16);
    beat(0, 32);
    chk("b38_seq", 256'(seq_err), 1);
    beat(1, 32);
    chk("b38_seq_clr", 256'(seq_err), 0);
    for (int k = 2; k < 8; k++) beat(k, 32);
    chk("b38_valid", 256'(digest_valid), 1);
    chk("b38_digest", digest, exp_b);
    idle();
    chk("b38_blk", 256'(blk_cnt), 4);

    digest_ready = 1'b0;
    for (int k = 0; k < 8; k++) beat(k, 16);
    chk("b39_valid", 256'(digest_valid), 1);
    for (int k = 0; k < 7; k++) begin
      beat(k, 32);
      chk("b39_hold", digest, exp_a);
    end
    beat(7, 32);
    chk("b39_ovr", 256'(overrun), 1);
    chk("b39_drop", 256'(drop_cnt), 1);
    chk("b39_keep", digest, exp_a);
    idle();
    chk("b39_ovr_clr", 256'(overrun), 0);
    chk("b39_blk_hold", 256'(blk_cnt), 4);
    digest_ready = 1'b1;
    idle();
    chk("b39_vclr", 256'(digest_valid), 0);
    chk("b39_blk", 256'(blk_cnt), 5);

    digest_ready = 1'b0;
    for (int k = 0; k < 8; k++) beat(k, 16);
    for (int k = 0; k < 7; k++) beat(k, 32);
    digest_ready = 1'b1;
    beat(7, 32);
    chk("b23_valid", 256'(digest_valid), 1);
    chk("b23_digest", digest, exp_b);
    chk("b23_blk", 256'(blk_cnt), 6);
    chk("b23_ovr", 256'(overrun), 0);
    chk("b23_drop", 256'(drop_cnt), 1);
    idle();
    chk("b23_vclr", 256'(digest_valid), 0);
    chk("b23_blk2", 256'(blk_cnt), 7);

    digest_ready = 1'b0;
    for (int k = 0; k < 8; k++) beat(k, 16);
    digest_ready = 1'b1;
    for (int k = 0; k < 5; k++) beat(k, 16);
    reset = 1'b0;
    #2;
    chk_zero("b40_async");
    step();
    reset = 1'b1;
    beat(1, 32);
    chk("b40_seq", 256'(seq_err), 1);
    for (int k = 0; k < 8; k++) beat(k, 32);
    chk("b40_valid", 256'(digest_valid), 1);
    chk("b40_digest", digest, exp_b);
    idle();
    chk("b40_blk", 256'(blk_cnt), 1);
    chk("b40_drop", 256'(drop_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
